// File: rtl/stack_seq_pkg.sv
// Shared encodings and state types for the stack-op sequencer and its byte engine.
package stack_seq_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_LDSP = 3'b100;

  localparam logic [7:0] STACK_TOP_DEF = 8'h7F;

  typedef enum logic [1:0] {IDLE, BYTE, LDSP, DONE} top_state_t;

  typedef enum logic [2:0] {B_IDLE, B_INC, B_WR, B_RA, B_RD, B_DEC} byte_state_t;

  function automatic logic is_pop_op(input logic [2:0] op);
    return (op == OP_POP) || (op == OP_RET);
  endfunction

  function automatic logic is_two_byte(input logic [2:0] op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

  // PUSH/POP/CALL/RET all live in the lower half of the op space.
  function automatic logic is_byte_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/stack_byte_engine.sv
// Single-byte push/pop engine: drives SP push/pop/rd strobes and the RAM byte port.
module stack_byte_engine
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STACK_TOP = STACK_TOP_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [DATA_W-1:0] byte_in,
  output logic              done,
  output logic [DATA_W-1:0] byte_out,
  output logic              ovf_hit,
  output logic              unf_hit,
  output logic              sp_push,
  output logic              sp_pop,
  output logic              sp_rd,
  input  logic [ADDR_W-1:0] sp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  byte_state_t state, state_nxt, launch;
  logic [DATA_W-1:0] byte_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= B_IDLE;
      byte_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == B_RD) byte_q <= ram_rdata;
    end
  end

  // done is raised in the last cycle of a byte so the next byte can start back-to-back.
  always_comb begin
    state_nxt = state;
    launch    = dir ? B_RA : B_INC;
    done      = 1'b0;
    ovf_hit   = 1'b0;
    unf_hit   = 1'b0;
    sp_push   = 1'b0;
    sp_pop    = 1'b0;
    sp_rd     = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      B_IDLE: if (start) state_nxt = launch;
      B_INC: begin
        sp_push   = 1'b1;
        sp_rd     = 1'b1;
        ovf_hit   = (sp_rdata == STACK_TOP);
        state_nxt = B_WR;
      end
      B_WR: begin
        sp_rd     = 1'b1;
        ram_addr  = sp_rdata;
        ram_we    = 1'b1;
        ram_wdata = byte_in;
        done      = 1'b1;
        state_nxt = start ? launch : B_IDLE;
      end
      B_RA: begin
        sp_rd     = 1'b1;
        ram_addr  = sp_rdata;
        ram_re    = 1'b1;
        unf_hit   = (sp_rdata == '0);
        state_nxt = B_RD;
      end
      B_RD: state_nxt = B_DEC;
      B_DEC: begin
        sp_pop    = 1'b1;
        done      = 1'b1;
        state_nxt = start ? launch : B_IDLE;
      end
      default: state_nxt = B_IDLE;
    endcase
  end

  assign byte_out = byte_q;

endmodule

// File: rtl/stack_op_sequencer.sv
// Command-level sequencer for PUSH/POP/CALL/RET/LDSP on an 8051-style stack.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STACK_TOP = STACK_TOP_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [2*DATA_W-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                ovf,
  output logic                unf,
  output logic                sp_push,
  output logic                sp_pop,
  output logic                sp_rd,
  output logic                sp_wr,
  output logic [ADDR_W-1:0]   sp_wdata,
  input  logic [ADDR_W-1:0]   sp_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  output logic                ram_re,
  input  logic [DATA_W-1:0]   ram_rdata
);

  top_state_t state, state_nxt;
  logic [2:0]          op_q;
  logic [2*DATA_W-1:0] data_q;
  logic [2*DATA_W-1:0] res_q;
  logic                idx_q;
  logic                ovf_pend;
  logic                unf_pend;
  logic                eng_start;
  logic                eng_dir;
  logic                eng_done;
  logic                eng_ovf_hit;
  logic                eng_unf_hit;
  logic [DATA_W-1:0]   eng_byte_in;
  logic [DATA_W-1:0]   eng_byte_out;

  // CALL pushes the low byte first; RET therefore pops the high byte first.
  assign eng_byte_in = idx_q ? data_q[2*DATA_W-1:DATA_W] : data_q[DATA_W-1:0];

  stack_byte_engine #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .STACK_TOP(STACK_TOP)
  ) u_engine (
    .clock    (clock),
    .reset    (reset),
    .start    (eng_start),
    .dir      (eng_dir),
    .byte_in  (eng_byte_in),
    .done     (eng_done),
    .byte_out (eng_byte_out),
    .ovf_hit  (eng_ovf_hit),
    .unf_hit  (eng_unf_hit),
    .sp_push  (sp_push),
    .sp_pop   (sp_pop),
    .sp_rd    (sp_rd),
    .sp_rdata (sp_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_rdata(ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The engine is started on the accept edge itself so its first strobe lands in N+1.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    eng_start = 1'b0;
    eng_dir   = is_pop_op(op_q);
    sp_wr     = 1'b0;
    sp_wdata  = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    ovf       = 1'b0;
    unf       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        eng_dir   = is_pop_op(cmd_op);
        if (cmd_valid) begin
          if (is_byte_op(cmd_op)) begin
            eng_start = 1'b1;
            state_nxt = BYTE;
          end else begin
            state_nxt = LDSP;
          end
        end
      end
      BYTE: begin
        if (eng_done) begin
          if (is_two_byte(op_q) && !idx_q) eng_start = 1'b1;
          else                             state_nxt = DONE;
        end
      end
      LDSP: begin
        if (op_q == OP_LDSP) begin
          sp_wr    = 1'b1;
          sp_wdata = data_q[ADDR_W-1:0];
        end
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = res_q;
        ovf       = ovf_pend;
        unf       = unf_pend;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= OP_PUSH;
      data_q   <= '0;
      res_q    <= '0;
      idx_q    <= 1'b0;
      ovf_pend <= 1'b0;
      unf_pend <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        res_q  <= '0;
        idx_q  <= 1'b0;
      end
      if (state == BYTE && eng_done) begin
        idx_q <= 1'b1;
        if (is_pop_op(op_q)) begin
          if (op_q == OP_RET && !idx_q) res_q[2*DATA_W-1:DATA_W] <= eng_byte_out;
          else                          res_q[DATA_W-1:0]        <= eng_byte_out;
        end
      end
      if (eng_ovf_hit) ovf_pend <= 1'b1;
      if (eng_unf_hit) unf_pend <= 1'b1;
      if (state == DONE) begin
        ovf_pend <= 1'b0;
        unf_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural stack pointer and RAM.
module tb_stack_op_sequencer;

  localparam logic [2:0] T_PUSH = 3'b000;
  localparam logic [2:0] T_POP  = 3'b001;
  localparam logic [2:0] T_CALL = 3'b010;
  localparam logic [2:0] T_RET  = 3'b011;
  localparam logic [2:0] T_LDSP = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        ovf, unf;
  logic        sp_push, sp_pop, sp_rd, sp_wr;
  logic [7:0]  sp_wdata, sp_rdata;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  logic [7:0]  sp_model;
  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;
  int          violations = 0;
  int          push_cnt = 0;
  int          strobe_cycles = 0;

  always #5 clock = ~clock;

  stack_op_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ovf(ovf), .unf(unf),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_rd(sp_rd), .sp_wr(sp_wr),
    .sp_wdata(sp_wdata), .sp_rdata(sp_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  // Stack pointer: wraps from the top of the stack to 00, resets to 07.
  assign sp_rdata = sp_rd ? sp_model : 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge clock) begin
    if (reset)        sp_model <= 8'h07;
    else if (sp_wr)   sp_model <= sp_wdata;
    else if (sp_push) sp_model <= (sp_model == 8'h7F) ? 8'h00 : sp_model + 8'd1;
    else if (sp_pop)  sp_model <= sp_model - 8'd1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
    if ((32'(sp_push) + 32'(sp_pop) + 32'(sp_wr)) > 1 || (ram_we && ram_re)) violations++;
    if (sp_push) push_cnt++;
    if (sp_push || sp_pop || sp_rd || sp_wr || ram_we || ram_re) strobe_cycles++;
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    int          lat;
    logic [15:0] rsp;
    logic        ovf;
    logic        unf;
    logic [7:0]  sp;
    logic        ram_chk;
    logic [7:0]  ram_a;
    logic [7:0]  ram_v;
  } vec_t;

  vec_t vecs [18];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Presents one command and returns at the first falling edge after it was accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data);
    int n = 0;
    @(negedge clock);
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 16'h0000;
  endtask

  task automatic waitResponse(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int rsp_seen;
    int p0;
    int s0;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 16'h0000;
    vecs[0]  = '{T_LDSP, 16'h0007, 2, 16'h0000, 1'b0, 1'b0, 8'h07, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{T_CALL, 16'h1234, 5, 16'h0000, 1'b0, 1'b0, 8'h09, 1'b1, 8'h08, 8'h34};
    vecs[2]  = '{T_RET,  16'h0000, 7, 16'h1234, 1'b0, 1'b0, 8'h07, 1'b1, 8'h09, 8'h12};
    vecs[3]  = '{T_LDSP, 16'h007F, 2, 16'h0000, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{T_PUSH, 16'h00AA, 3, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'hAA};
    vecs[5]  = '{T_LDSP, 16'h0000, 2, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{T_POP,  16'h0000, 4, 16'h00AA, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{3'b110, 16'hFFFF, 2, 16'h0000, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{3'b101, 16'h1234, 2, 16'h0000, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{3'b111, 16'hABCD, 2, 16'h0000, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{T_LDSP, 16'h0010, 2, 16'h0000, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{T_PUSH, 16'h003C, 3, 16'h0000, 1'b0, 1'b0, 8'h11, 1'b1, 8'h11, 8'h3C};
    vecs[12] = '{T_POP,  16'h0000, 4, 16'h003C, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 8'h00};
    vecs[13] = '{T_CALL, 16'hBEEF, 5, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b1, 8'h12, 8'hBE};
    vecs[14] = '{T_RET,  16'h0000, 7, 16'hBEEF, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 8'h00};
    vecs[15] = '{T_LDSP, 16'h007E, 2, 16'h0000, 1'b0, 1'b0, 8'h7E, 1'b0, 8'h00, 8'h00};
    vecs[16] = '{T_CALL, 16'h5566, 5, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7F, 8'h66};
    vecs[17] = '{T_RET,  16'h0000, 7, 16'h5500, 1'b0, 1'b1, 8'hFE, 1'b1, 8'h00, 8'h55};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_strobes",
                32'({rsp_valid, ovf, unf, sp_push, sp_pop, sp_rd, sp_wr, ram_we, ram_re}), 32'd0);
    checkOutput("reset_data", {rsp_data, ram_addr, ram_wdata}, 32'd0);
    checkOutput("reset_sp_wdata", 32'(sp_wdata), 32'd0);

    $display("[TB] push timing from SP=07");
    applyStimulus(T_PUSH, 16'h005A);
    checkOutput("push_n1_strobe", 32'({sp_push, sp_rd, ram_we}), 32'b110);
    @(negedge clock);
    checkOutput("push_n2_write", {7'd0, sp_push, ram_we, ram_re, ram_addr, ram_wdata, 6'd0},
                {7'd0, 1'b0, 1'b1, 1'b0, 8'h08, 8'h5A, 6'd0});
    @(negedge clock);
    checkOutput("push_n3_rsp", 32'(rsp_valid), 32'd1);
    @(negedge clock);
    checkOutput("push_sp", 32'(sp_model), 32'h08);
    checkOutput("push_ram", 32'(mem[8'h08]), 32'h5A);

    $display("[TB] vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data);
      waitResponse(lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].rsp));
      checkOutput($sformatf("v%0d_ovf_unf", i), 32'({ovf, unf}), 32'({vecs[i].ovf, vecs[i].unf}));
      @(negedge clock);
      checkOutput($sformatf("v%0d_pulse_end", i), 32'({rsp_valid, ovf, unf, rsp_data}), 32'd0);
      checkOutput($sformatf("v%0d_sp", i), 32'(sp_model), 32'(vecs[i].sp));
      if (vecs[i].ram_chk)
        checkOutput($sformatf("v%0d_ram", i), 32'(mem[vecs[i].ram_a]), 32'(vecs[i].ram_v));
    end

    $display("[TB] reset during CALL");
    applyStimulus(T_LDSP, 16'h0007);
    waitResponse(lat);
    applyStimulus(T_CALL, 16'hABCD);
    cnt = 0;
    while (!ram_we && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("rst_call_first_we", 32'(ram_we), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    cnt = 0;
    rsp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (sp_push || sp_pop || sp_rd || sp_wr || ram_we || ram_re) cnt++;
      if (rsp_valid) rsp_seen++;
      @(negedge clock);
    end
    checkOutput("rst_no_strobes", 32'(cnt), 32'd0);
    checkOutput("rst_no_rsp", 32'(rsp_seen), 32'd0);
    checkOutput("rst_ram_kept", 32'(mem[8'h08]), 32'hCD);

    $display("[TB] cmd_valid held while busy, then op 110");
    p0 = push_cnt;
    @(negedge clock);
    cmd_op = T_PUSH; cmd_data = 16'h0077; cmd_valid = 1'b1;
    checkOutput("hold_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    cmd_op = 3'b110; cmd_data = 16'hFFFF;
    waitResponse(lat);
    checkOutput("hold_push_latency", 32'(lat), 32'd3);
    checkOutput("hold_busy_ready", 32'(cmd_ready), 32'd0);
    s0 = strobe_cycles;
    cnt = 0;
    @(negedge clock);
    while (!cmd_ready && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 16'h0000;
    waitResponse(lat);
    checkOutput("op110_latency", 32'(lat), 32'd2);
    checkOutput("op110_rsp", 32'({ovf, unf, rsp_data}), 32'd0);
    checkOutput("op110_no_strobes", 32'(strobe_cycles - s0), 32'd0);
    checkOutput("hold_single_push", 32'(push_cnt - p0), 32'd1);
    checkOutput("hold_sp", 32'(sp_model), 32'h08);
    checkOutput("hold_ram", 32'(mem[8'h08]), 32'h77);

    @(negedge clock);
    checkOutput("strobe_exclusive", 32'(violations), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
